if_fetch_ctrl: RTL and testbench

- Fetch-side responder to the load-use hazard interface (stall, pc_write, if_id_write) of the pipelined KGP-RISC core.
- Owns the PC, issues requests to a variable-latency instruction memory, and owns the IF/ID pipeline register.
- Freezes on stall, redirects and flushes on a taken branch from EX, and drives the ID/EX bubble select.

---
 rtl/kgp_pipe_pkg.sv | 17 +
 rtl/if_id_reg.sv | 50 +++++
 rtl/if_fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_pipe_pkg.sv
// Shared definitions for the KGP-RISC pipeline front end.
// Holds default widths, the reset PC, the bubble instruction word and the
// fetch FSM state encoding used by if_fetch_ctrl.
package kgp_pipe_pkg;

    localparam int          KGP_XLEN      = 32;
    localparam int          ILEN          = 32;      // instruction word width
    localparam logic [31:0] KGP_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] KGP_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // issue a request for pc
        S_WAIT = 2'd1,   // one request outstanding
        S_HOLD = 2'd2    // word parked in the skid buffer, IF/ID not writable
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush_i           load a bubble {0, NOP_INSTR, 0}; wins over load_i
//   load_i            load {pc_i, instr_i, valid_i}
//   pc_i/instr_i/valid_i   next contents when load_i=1
//   pc_o/instr_o/valid_o   registered contents
module if_id_reg
    import kgp_pipe_pkg::*;
#(
    parameter int               XLEN      = KGP_XLEN,
    parameter logic [ILEN-1:0]  NOP_INSTR = KGP_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [ILEN-1:0] instr_i,
    input  logic            valid_i,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] instr_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q;
    logic [ILEN-1:0] instr_q;
    logic            valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= valid_i;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch controller for the KGP-RISC pipeline.
// Owns the PC, issues single-outstanding requests to a variable-latency
// instruction memory, parks a returned word in a skid buffer while IF/ID is
// frozen, and redirects/flushes on a taken branch from EX.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   stall, pc_write, if_id_write  load-use hazard controls
//   branch_taken, branch_target   redirect from EX
//   imem_req, imem_addr           fetch request (one cycle per request)
//   imem_ready, imem_rdata        fetch response
//   pc                            current fetch PC
//   if_id_pc/instr/valid          IF/ID register contents
//   id_ex_bubble                  select NOP controls into ID/EX
module if_fetch_ctrl
    import kgp_pipe_pkg::*;
#(
    parameter int               XLEN      = KGP_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(KGP_RESET_PC),
    parameter logic [ILEN-1:0]  NOP_INSTR = KGP_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            pc_write,
    input  logic            if_id_write,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] if_id_pc,
    output logic [ILEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            id_ex_bubble
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;   // outstanding response must be dropped
    logic [ILEN-1:0] skid_q, skid_d;

    logic            xfer;               // a word moves into IF/ID this cycle
    logic [ILEN-1:0] xfer_word;
    logic [XLEN-1:0] br_tgt;

    assign br_tgt = branch_target & ~XLEN'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            skid_q  <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        flush_d   = flush_q;
        skid_d    = skid_q;
        xfer      = 1'b0;
        xfer_word = skid_q;

        if (branch_taken) begin
            pc_d = br_tgt;
            case (state_q)
                S_REQ: begin
                    // The request going out this cycle is for the old path.
                    flush_d = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_ready) begin
                        flush_d = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        flush_d = 1'b1;
                    end
                end
                default: begin
                    skid_d  = NOP_INSTR;
                    state_d = S_REQ;
                end
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    // Any imem_ready here is a leftover from before reset.
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_ready) begin
                        if (flush_q) begin
                            flush_d = 1'b0;
                            state_d = S_REQ;
                        end else if (if_id_write) begin
                            xfer      = 1'b1;
                            xfer_word = imem_rdata;
                            state_d   = S_REQ;
                        end else begin
                            skid_d  = imem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (if_id_write) begin
                        xfer      = 1'b1;
                        xfer_word = skid_q;
                        state_d   = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
            // pc_write=0 on a transfer refetches the same address.
            if (xfer && pc_write) begin
                pc_d = pc_q + XLEN'(4);
            end
        end
    end

    // Gated by rst so the strobe reads 0 while reset is held.
    assign imem_req     = (state_q == S_REQ) && !rst;
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign id_ex_bubble = stall | branch_taken;

    // Starvation (if_id_write=1, no transfer) loads {pc, NOP, 0}.
    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .flush_i (branch_taken),
        .load_i  (if_id_write),
        .pc_i    (pc_q),
        .instr_i (xfer ? xfer_word : NOP_INSTR),
        .valid_i (xfer),
        .pc_o    (if_id_pc),
        .instr_o (if_id_instr),
        .valid_o (if_id_valid)
    );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;
    import kgp_pipe_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, pc_write = 1'b1, if_id_write = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc, if_id_pc, if_id_instr;
    logic        if_id_valid, id_ex_bubble;

    always #5 clk = ~clk;

    if_fetch_ctrl #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .id_ex_bubble  (id_ex_bubble)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instruction memory responder ----------------
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          mem_lat = 1;      // 0 = random latency 1..4 per request
    bit          force_stale = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive inputs at the falling edge, settle, accept a request.
    task automatic cyc(input logic [2:0] haz, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        {stall, pc_write, if_id_write} = haz;
        branch_taken  = br;
        branch_target = tgt;
        if (force_stale) begin
            imem_ready  = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            force_stale = 0;
        end else if (mem_busy && mem_cnt == 0) begin
            imem_ready = 1'b1;
            imem_rdata = mem_word(mem_addr);
            mem_busy   = 0;
        end else begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            if (mem_busy) mem_cnt--;
        end
        #1;
        if (imem_req === 1'b1) begin
            mem_busy = 1;
            mem_addr = imem_addr;
            mem_cnt  = (mem_lat == 0) ? int'($urandom_range(0, 3)) : mem_lat - 1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_busy = 0; force_stale = 0; imem_ready = 1'b0;
        {stall, pc_write, if_id_write} = 3'b011;
        branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] m_pc, m_ipc, m_iinstr, m_req_addr;
    bit          m_ivalid, m_issue, m_inflight, m_discard, m_parked;

    task automatic model_reset();
        m_pc = 32'h0; m_ipc = 32'h0; m_iinstr = NOP; m_ivalid = 0;
        m_issue = 1; m_inflight = 0; m_discard = 0; m_parked = 0; m_req_addr = 32'h0;
    endtask

    task automatic model_step();
        bit got = 0;
        if (branch_taken) begin
            if (m_issue) begin
                m_req_addr = m_pc; m_issue = 0; m_inflight = 1; m_discard = 1;
            end else if (m_inflight) begin
                if (imem_ready) begin m_inflight = 0; m_discard = 0; m_issue = 1; end
                else m_discard = 1;
            end else if (m_parked) begin
                m_parked = 0; m_issue = 1;
            end
            m_pc = branch_target & ~32'h3;
            m_ipc = 32'h0; m_iinstr = NOP; m_ivalid = 0;
        end else begin
            if (m_issue) begin
                m_req_addr = m_pc; m_issue = 0; m_inflight = 1;
            end else if (m_inflight && imem_ready) begin
                m_inflight = 0;
                if (m_discard) begin m_discard = 0; m_issue = 1; end
                else if (if_id_write) begin got = 1; m_issue = 1; end
                else m_parked = 1;
            end else if (m_parked && if_id_write) begin
                got = 1; m_parked = 0; m_issue = 1;
            end
            if (if_id_write) begin
                m_ipc = m_pc;
                m_iinstr = got ? mem_word(m_req_addr) : NOP;
                m_ivalid = got;
            end
            if (got) $display("xfer pc=%08h instr=%08h pc_write=%0b", m_pc, mem_word(m_req_addr), pc_write);
            if (got && pc_write) m_pc = m_pc + 32'h4;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk); #1;
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b exp 0", if_id_valid); end
        n_cmp++; if (if_id_instr !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h exp %h", if_id_instr, NOP); end
        n_cmp++; if (if_id_pc !== 32'h0) begin n_bad++; $display("FAIL reset_ifid_pc: got %h exp 0", if_id_pc); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b exp 0", imem_req); end
        $display("reset checked");
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] addrs[$];
        logic [31:0] exp_a;
        apply_reset(); mem_lat = 1;
        for (int i = 0; i < 7; i++) begin
            cyc(3'b011, 1'b0, 32'h0);
            if (imem_req === 1'b1) addrs.push_back(imem_addr);
            if (i == 2) begin
                n_cmp++; if (if_id_valid !== 1'b1) begin n_bad++; $display("FAIL seq_first_valid: got %b exp 1", if_id_valid); end
                n_cmp++; if (if_id_instr !== mem_word(32'h0)) begin n_bad++; $display("FAIL seq_first_instr: got %h exp %h", if_id_instr, mem_word(32'h0)); end
            end
            if (i == 6) begin
                n_cmp++; if (pc !== 32'hC) begin n_bad++; $display("FAIL seq_pc: got %h exp %h", pc, 32'hC); end
            end
        end
        n_cmp++;
        if (addrs.size() < 3) begin
            n_bad++; $display("FAIL seq_req_count: got %0d exp >=3", addrs.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                exp_a = 32'(4 * k);
                n_cmp++; if (addrs[k] !== exp_a) begin n_bad++; $display("FAIL seq_addr%0d: got %h exp %h", k, addrs[k], exp_a); end
            end
        end
        $display("sequential fetch checked, %0d requests", addrs.size());
    endtask

    task automatic test_stall_skid();
        apply_reset(); mem_lat = 1;
        cyc(3'b011, 1'b0, 32'h0);   // request 0
        cyc(3'b011, 1'b0, 32'h0);   // word 0 -> IF/ID
        cyc(3'b100, 1'b0, 32'h0);   // request 4, IF/ID frozen
        cyc(3'b100, 1'b0, 32'h0);   // word 4 arrives during stall
        n_cmp++; if (id_ex_bubble !== 1'b1) begin n_bad++; $display("FAIL stall_bubble: got %b exp 1", id_ex_bubble); end
        cyc(3'b011, 1'b0, 32'h0);   // parked; release
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_hold_req: got %b exp 0", imem_req); end
        n_cmp++; if (if_id_instr !== mem_word(32'h0)) begin n_bad++; $display("FAIL stall_instr_held: got %h exp %h", if_id_instr, mem_word(32'h0)); end
        n_cmp++; if (pc !== 32'h4) begin n_bad++; $display("FAIL stall_pc_held: got %h exp %h", pc, 32'h4); end
        n_cmp++; if (id_ex_bubble !== 1'b0) begin n_bad++; $display("FAIL stall_bubble_off: got %b exp 0", id_ex_bubble); end
        cyc(3'b011, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h8) begin n_bad++; $display("FAIL skid_pc: got %h exp %h", pc, 32'h8); end
        n_cmp++; if (if_id_instr !== mem_word(32'h4)) begin n_bad++; $display("FAIL skid_instr: got %h exp %h", if_id_instr, mem_word(32'h4)); end
        n_cmp++; if (if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin n_bad++; $display("FAIL skid_pc_valid: got %h/%b exp %h/1", if_id_pc, if_id_valid, 32'h4); end
        $display("load-use stall with skid checked");
    endtask

    task automatic test_latency3();
        apply_reset(); mem_lat = 3;
        for (int i = 0; i < 5; i++) begin
            cyc(3'b011, 1'b0, 32'h0);
            if (i == 1 || i == 2) begin
                n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL lat_req_c%0d: got %b exp 0", i, imem_req); end
            end
            if (i == 2 || i == 3) begin
                n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin n_bad++; $display("FAIL lat_bubble_c%0d: got %b/%h exp 0/%h", i, if_id_valid, if_id_instr, NOP); end
            end
            if (i == 4) begin
                n_cmp++; if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h0)) begin n_bad++; $display("FAIL lat_word: got %b/%h exp 1/%h", if_id_valid, if_id_instr, mem_word(32'h0)); end
            end
        end
        mem_lat = 1;
        $display("3-cycle latency checked");
    endtask

    task automatic test_branch_same_cycle();
        apply_reset(); mem_lat = 1;
        cyc(3'b011, 1'b0, 32'h0);          // request 0
        cyc(3'b011, 1'b1, 32'h0000_0043);  // response + branch
        n_cmp++; if (id_ex_bubble !== 1'b1) begin n_bad++; $display("FAIL brs_bubble: got %b exp 1", id_ex_bubble); end
        cyc(3'b011, 1'b0, 32'h0);
        n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0) begin n_bad++; $display("FAIL brs_ifid: got %h/%h/%b exp 0/%h/0", if_id_pc, if_id_instr, if_id_valid, NOP); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_bad++; $display("FAIL brs_next_addr: got %b/%h exp 1/%h", imem_req, imem_addr, 32'h40); end
        cyc(3'b011, 1'b0, 32'h0);
        cyc(3'b011, 1'b0, 32'h0);
        n_cmp++; if (if_id_instr !== mem_word(32'h40) || if_id_pc !== 32'h40) begin n_bad++; $display("FAIL brs_target_word: got %h@%h exp %h@%h", if_id_instr, if_id_pc, mem_word(32'h40), 32'h40); end
        $display("branch with same-cycle response checked");
    endtask

    task automatic test_branch_before_resp();
        apply_reset(); mem_lat = 1;
        cyc(3'b011, 1'b0, 32'h0);   // request 0
        cyc(3'b011, 1'b0, 32'h0);   // word 0 -> IF/ID
        mem_lat = 2;
        cyc(3'b100, 1'b0, 32'h0);   // request 4, IF/ID frozen (valid word 0)
        cyc(3'b100, 1'b1, 32'h80);  // branch before response, if_id_write=0
        cyc(3'b011, 1'b0, 32'h0);   // stale response arrives
        n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0) begin n_bad++; $display("FAIL brw_flush: got %h/%h/%b exp 0/%h/0", if_id_pc, if_id_instr, if_id_valid, NOP); end
        n_cmp++; if (pc !== 32'h80 || imem_req !== 1'b0) begin n_bad++; $display("FAIL brw_pc_req: got %h/%b exp %h/0", pc, imem_req, 32'h80); end
        cyc(3'b011, 1'b0, 32'h0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_bad++; $display("FAIL brw_next_addr: got %b/%h exp 1/%h", imem_req, imem_addr, 32'h80); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL brw_stale_dropped: got %b exp 0", if_id_valid); end
        repeat (3) cyc(3'b011, 1'b0, 32'h0);
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h80)) begin n_bad++; $display("FAIL brw_target_word: got %b/%h exp 1/%h", if_id_valid, if_id_instr, mem_word(32'h80)); end
        mem_lat = 1;
        $display("branch before response checked");
    endtask

    task automatic test_reset_mid_hold();
        apply_reset(); mem_lat = 1;
        cyc(3'b011, 1'b0, 32'h0);
        cyc(3'b011, 1'b0, 32'h0);
        cyc(3'b100, 1'b0, 32'h0);
        cyc(3'b100, 1'b0, 32'h0);   // word 4 parked
        cyc(3'b100, 1'b0, 32'h0);   // in S_HOLD
        n_cmp++; if (if_id_valid !== 1'b1 || pc !== 32'h4) begin n_bad++; $display("FAIL hold_pre_reset: got %b/%h exp 1/%h", if_id_valid, pc, 32'h4); end
        #1 rst = 1'b1;
        mem_busy = 0;
        #1;
        n_cmp++; if (pc !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0 || imem_req !== 1'b0) begin
            n_bad++; $display("FAIL async_reset: got pc=%h ifid=%h/%h/%b req=%b exp 0/0/%h/0/0", pc, if_id_pc, if_id_instr, if_id_valid, imem_req, NOP);
        end
        @(posedge clk); #1 rst = 1'b0;
        force_stale = 1;
        {stall, pc_write, if_id_write} = 3'b011;
        cyc(3'b011, 1'b0, 32'h0);   // stale ready in S_REQ
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL post_reset_req: got %b/%h exp 1/%h", imem_req, imem_addr, 32'h0); end
        cyc(3'b011, 1'b0, 32'h0);
        cyc(3'b011, 1'b0, 32'h0);
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h0)) begin n_bad++; $display("FAIL post_reset_word: got %b/%h exp 1/%h", if_id_valid, if_id_instr, mem_word(32'h0)); end
        $display("async reset mid-hold checked");
    endtask

    task automatic test_random();
        logic [2:0]  haz;
        logic        br;
        logic [31:0] tgt;
        int          r;
        apply_reset(); mem_lat = 0;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 75) haz = 3'b011;
            else if (r < 92) haz = 3'b100;
            else haz = 3'($urandom);
            br  = ($urandom_range(0, 99) < 7);
            tgt = $urandom;
            cyc(haz, br, tgt);
            n_cmp++; if (imem_req !== m_issue) begin n_bad++; $display("FAIL rnd_req@%0d: got %b exp %b", i, imem_req, m_issue); end
            if (m_issue) begin
                n_cmp++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr@%0d: got %h exp %h", i, imem_addr, m_pc); end
            end
            n_cmp++; if (pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc@%0d: got %h exp %h", i, pc, m_pc); end
            n_cmp++; if (if_id_pc !== m_ipc) begin n_bad++; $display("FAIL rnd_ifid_pc@%0d: got %h exp %h", i, if_id_pc, m_ipc); end
            n_cmp++; if (if_id_instr !== m_iinstr) begin n_bad++; $display("FAIL rnd_ifid_instr@%0d: got %h exp %h", i, if_id_instr, m_iinstr); end
            n_cmp++; if (if_id_valid !== m_ivalid) begin n_bad++; $display("FAIL rnd_ifid_valid@%0d: got %b exp %b", i, if_id_valid, m_ivalid); end
            n_cmp++; if (id_ex_bubble !== (haz[2] | br)) begin n_bad++; $display("FAIL rnd_bubble@%0d: got %b exp %b", i, id_ex_bubble, haz[2] | br); end
            model_step();
        end
        mem_lat = 1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_skid();
        test_latency3();
        test_branch_same_cycle();
        test_branch_before_resp();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
